dct_mac_seq: RTL and testbench

DCT_MAC_SEQ -- requirements
Module: dct_mac_seq

---
 rtl/dct_mac_seq.sv | 115 +++++++++++
 tb/tb_dct_mac_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_mac_seq.sv
// Sequential 13x23 DCT multiply-accumulate for log-mel to cepstrum.
// One MAC per cycle; 25 cycles per output coefficient.
module dct_mac_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        reg_wr,
   output logic [4:0]  reg_addr,
   input  logic [15:0] reg_data,
   output logic [8:0]  coef_addr,
   input  logic [15:0] coef_in,
   output logic [15:0] cep_out,
   output logic [3:0]  cep_idx,
   output logic        cep_valid,
   output logic        busy,
   output logic        done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_DRAIN  = 3'd2;
   localparam logic [2:0] S_OUTPUT = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   logic [2:0]         state;
   logic [3:0]         k;
   logic [4:0]         n;
   logic               acc_en;
   logic signed [36:0] acc;
   logic signed [31:0] prod;
   logic signed [36:0] sh;
   logic [15:0]        sat;

   assign reg_wr = 1'b0;
   assign busy   = (state != S_IDLE);

   always_comb begin
      prod = $signed(reg_data) * $signed(coef_in);
      sh   = acc >>> 14;
      if (sh > 37'sd32767)
         sat = 16'h7fff;
      else if (sh < -37'sd32768)
         sat = 16'h8000;
      else
         sat = sh[15:0];
   end

   // acc_en marks the cycle whose reg_data/coef_in answer an ISSUE address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         k         <= '0;
         n         <= '0;
         acc_en    <= 1'b0;
         acc       <= '0;
         reg_addr  <= '0;
         coef_addr <= '0;
         cep_out   <= '0;
         cep_idx   <= '0;
         cep_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         cep_valid <= 1'b0;
         done      <= 1'b0;
         acc_en    <= (state == S_ISSUE);
         if (acc_en)
            acc <= acc + {{5{prod[31]}}, prod};
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_ISSUE;
                  k         <= '0;
                  n         <= '0;
                  reg_addr  <= '0;
                  coef_addr <= '0;
                  acc       <= '0;
               end
            end
            S_ISSUE: begin
               if (n == 5'd22) begin
                  state <= S_DRAIN;
               end else begin
                  n         <= n + 5'd1;
                  reg_addr  <= n + 5'd1;
                  coef_addr <= coef_addr + 9'd1;
               end
            end
            S_DRAIN: state <= S_OUTPUT;
            S_OUTPUT: begin
               cep_valid <= 1'b1;
               cep_out   <= sat;
               cep_idx   <= k;
               acc       <= '0;
               n         <= '0;
               reg_addr  <= '0;
               if (k == 4'd12) begin
                  state     <= S_FINISH;
                  coef_addr <= '0;
               end else begin
                  state     <= S_ISSUE;
                  k         <= k + 4'd1;
                  coef_addr <= coef_addr + 9'd1;
               end
            end
            S_FINISH: begin
               done  <= 1'b1;
               state <= S_IDLE;
               k     <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dct_mac_seq.sv
// Scoreboard bench for dct_mac_seq with synchronous ROM/RAM models
// and a plain-arithmetic reference for each cepstral coefficient.
module tb_dct_mac_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        reg_wr;
   logic [4:0]  reg_addr;
   logic [15:0] reg_data;
   logic [8:0]  coef_addr;
   logic [15:0] coef_in;
   logic [15:0] cep_out;
   logic [3:0]  cep_idx;
   logic        cep_valid;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   dct_mac_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_data  (reg_data),
      .coef_addr (coef_addr),
      .coef_in   (coef_in),
      .cep_out   (cep_out),
      .cep_idx   (cep_idx),
      .cep_valid (cep_valid),
      .busy      (busy),
      .done      (done)
   );

   logic signed [15:0] regmem [23];
   logic signed [15:0] coefmem [299];

   // one-cycle read latency memories
   always @(posedge clk) begin
      reg_data <= (reg_addr < 5'd23) ? regmem[reg_addr] : 16'h0;
      coef_in  <= (coef_addr < 9'd299) ? coefmem[coef_addr] : 16'h0;
   end

   typedef struct {
      int k;
      int val;
      int at;
   } exp_t;

   exp_t sbq[$];
   int   dq[$];
   int   cyc = 0;
   int   fstart = 0;
   bit   active = 1'b0;
   int   last_val = 0;
   int   last_idx = 0;
   int   compared = 0;
   int   mismatched = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d",
                  name, cyc, act, exp);
      end
   endtask

   function automatic int model(input int k);
      longint s = 0;
      for (int i = 0; i < 23; i++)
         s += longint'(regmem[i]) * longint'(coefmem[k*23+i]);
      s = s >>> 14;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return int'(s);
   endfunction

   // monitor: pops the scoreboard whenever the DUT presents a result
   always @(negedge clk) begin
      int   d;
      exp_t e;
      if (rst_n) begin
         d = cyc - fstart;
         check("reg_wr", int'(reg_wr), 0);
         if (cep_valid) begin
            if (sbq.size() == 0) begin
               check("spurious_strobe", 1, 0);
            end else begin
               e = sbq.pop_front();
               check("cep_out", int'($signed(cep_out)), e.val);
               check("cep_idx", int'(cep_idx), e.k);
               check("strobe_cycle", cyc, e.at);
               last_val = e.val;
               last_idx = e.k;
            end
         end else begin
            check("hold_out", int'($signed(cep_out)), last_val);
            check("hold_idx", int'(cep_idx), last_idx);
         end
         if (done) begin
            if (dq.size() == 0)
               check("spurious_done", 1, 0);
            else
               check("done_cycle", cyc, dq.pop_front());
            check("busy_at_done", int'(busy), 0);
            active = 1'b0;
         end
         if (active && d >= 0 && d < 325 && (d % 25) < 23) begin
            check("reg_addr", int'(reg_addr), d % 25);
            check("coef_addr", int'(coef_addr), (d / 25) * 23 + d % 25);
         end else if (!busy) begin
            check("idle_reg_addr", int'(reg_addr), 0);
            check("idle_coef_addr", int'(coef_addr), 0);
         end
         if (active && d >= 0 && d < 326)
            check("busy", int'(busy), 1);
      end
   end

   task automatic fill_const(input int r, input int c);
      for (int i = 0; i < 23; i++) regmem[i] = 16'(r);
      for (int i = 0; i < 299; i++) coefmem[i] = 16'(c);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 23; i++) regmem[i] = 16'($urandom);
      for (int i = 0; i < 299; i++)
         coefmem[i] = 16'(int'($urandom_range(0, 32768)) - 16384);
   endtask

   task automatic start_frame();
      @(negedge clk);
      fstart = cyc + 1;
      active = 1'b1;
      for (int k = 0; k < 13; k++)
         sbq.push_back('{k, model(k), fstart + 25 * (k + 1)});
      dq.push_back(fstart + 326);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (dq.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (dq.size() != 0) check("done_timeout", 0, 1);
      check("leftover_results", sbq.size(), 0);
      dq.delete();
      sbq.delete();
      active = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cep_out"}, int'(cep_out), 0);
      check({tag, "_cep_idx"}, int'(cep_idx), 0);
      check({tag, "_cep_valid"}, int'(cep_valid), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_reg_addr"}, int'(reg_addr), 0);
      check({tag, "_coef_addr"}, int'(coef_addr), 0);
      check({tag, "_reg_wr"}, int'(reg_wr), 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      fill_const(0, 0);
      #1 rst_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      fill_const(1, 16384);
      start_frame();
      wait_done();

      fill_const(32767, 16383);
      start_frame();
      wait_done();

      fill_const(-32768, 16384);
      start_frame();
      wait_done();

      fill_const(0, 1);
      regmem[0] = -16'sd1;
      start_frame();
      wait_done();

      for (int f = 0; f < 3; f++) begin
         fill_random();
         start_frame();
         wait_done();
      end

      fill_random();
      start_frame();
      while (cyc < fstart + 99) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      fill_random();
      start_frame();
      while (cyc < fstart + 59) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      active = 1'b0;
      sbq.delete();
      dq.delete();
      last_val = 0;
      last_idx = 0;
      #1 check_all_zero("midreset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("busy_after_abandon", int'(busy), 0);

      fill_random();
      start_frame();
      wait_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
